// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller.
// Launches one bus transaction per load/store, stalls the pipeline until the
// memory acknowledges or the wait times out, and feeds the MEM/WB register.
//
// Bus handshake: dmem_req is registered and stays high for the whole WAIT
// state. dmem_addr, dmem_wdata and dmem_we are captured on entry to WAIT and
// held stable until the access ends. dmem_ack is a one-cycle completion strobe.
// It is honoured only in WAIT; in that cycle dmem_rdata must carry the load data.
module mem_access_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    // EX/MEM register
    input  logic        mem_reg_write,
    input  logic        mem_mem_read,
    input  logic        mem_mem_write,
    input  logic        mem_mem_to_reg,
    input  logic [15:0] mem_alu_result,
    input  logic [15:0] mem_write_data,
    input  logic [2:0]  mem_write_reg,
    // data-memory bus
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_ack,
    // hazard unit
    output logic        stall,
    // MEM/WB register
    output logic        wb_reg_write,
    output logic [2:0]  wb_write_reg,
    output logic [15:0] wb_write_data,
    // status / debug
    output logic        bus_err,
    output logic        dbg_state
);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    // Counter must hold the value TIMEOUT itself without wrapping.
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] wait_cnt;
    logic          access;
    logic          timeout;

    // A load and a store in the same instruction is treated as a store.
    always_comb begin
        access = mem_mem_read | mem_mem_write;
    end

    // Next-state, stall and timeout decode. An ack on the timeout cycle wins.
    always_comb begin
        next_state = state;
        stall      = 1'b0;
        bus_err    = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    stall      = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (dmem_ack) begin
                    next_state = IDLE;
                end else if (wait_cnt == TO_VAL) begin
                    timeout    = 1'b1;
                    bus_err    = 1'b1;
                    next_state = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
        // Keep combinational outputs quiet while reset is held.
        if (!rst_n) begin
            stall   = 1'b0;
            bus_err = 1'b0;
            timeout = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Bus request and access attributes, captured when the access launches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            dmem_req <= (next_state == WAIT);
            if (state == IDLE && access) begin
                dmem_addr  <= mem_alu_result;
                dmem_wdata <= mem_write_data;
                dmem_we    <= mem_mem_write;
            end
        end
    end

    // Wait counter: zero on WAIT entry, counts each un-acked WAIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == WAIT && next_state == WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // MEM/WB register: bubble while stalled or on a timed-out access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_reg_write  <= 1'b0;
            wb_write_reg  <= '0;
            wb_write_data <= '0;
        end else if (stall || timeout) begin
            wb_reg_write  <= 1'b0;
            wb_write_reg  <= '0;
            wb_write_data <= '0;
        end else begin
            wb_reg_write  <= mem_reg_write;
            wb_write_reg  <= mem_write_reg;
            wb_write_data <= (mem_mem_to_reg && mem_mem_read && !mem_mem_write)
                             ? dmem_rdata : mem_alu_result;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: table of single-cycle ALU vectors plus
// hand-written load/store/timeout/reset sequences.
module tb_mem_access_ctrl;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
    logic [15:0] mem_alu_result, mem_write_data;
    logic [2:0]  mem_write_reg;
    logic        dmem_req, dmem_we;
    logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        stall, wb_reg_write, bus_err, dbg_state;
    logic [2:0]  wb_write_reg;
    logic [15:0] wb_write_data;

    int total = 0;
    int bad   = 0;

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .mem_mem_to_reg(mem_mem_to_reg),
        .mem_alu_result(mem_alu_result), .mem_write_data(mem_write_data),
        .mem_write_reg(mem_write_reg),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall(stall), .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
        .wb_write_data(wb_write_data), .bus_err(bus_err), .dbg_state(dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rw, m2r, ack;
        logic [15:0] alu, rdata;
        logic [2:0]  wreg;
        logic        e_rw;
        logic [2:0]  e_reg;
        logic [15:0] e_data;
    } vec_t;

    vec_t vecs[5];

    // access sequence results
    int          n_stall, n_cyc, err_k;
    logic [15:0] a_seen, d_seen;
    logic        w_seen;
    bit          stable_ok, bubble_ok, finished;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic rw, input logic rd, input logic wr, input logic m2r,
                          input logic [15:0] alu, input logic [15:0] wd, input logic [2:0] wreg);
        mem_reg_write  = rw;
        mem_mem_read   = rd;
        mem_mem_write  = wr;
        mem_mem_to_reg = m2r;
        mem_alu_result = alu;
        mem_write_data = wd;
        mem_write_reg  = wreg;
    endtask

    // Memory responder: acks ack_delay cycles after req rises (-1 = never).
    // Called just after a posedge with the access already on the inputs;
    // returns just after the edge that completes the access.
    task automatic do_access(input int ack_delay, input logic [15:0] rd);
        int k;
        bit done;
        n_stall = 0; n_cyc = 0; err_k = -1; k = -1;
        stable_ok = 1; bubble_ok = 1; finished = 0; done = 0;
        a_seen = '0; d_seen = '0; w_seen = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            if (dmem_req) begin
                k++;
                if (k == 0) begin
                    a_seen = dmem_addr; d_seen = dmem_wdata; w_seen = dmem_we;
                end else if (dmem_addr !== a_seen || dmem_wdata !== d_seen || dmem_we !== w_seen) begin
                    stable_ok = 0;
                end
            end
            if (c > 0 && (wb_reg_write !== 1'b0 || wb_write_data !== 16'h0)) bubble_ok = 0;
            dmem_ack   = dmem_req && (k == ack_delay);
            dmem_rdata = rd;
            #1;
            n_cyc++;
            if (stall) n_stall++;
            if (bus_err) err_k = k;
            if (!stall) begin
                done = 1;
                finished = 1;
            end
            tick();
            dmem_ack = 1'b0;
        end
    endtask

    initial begin
        // rw m2r ack alu rdata wreg | e_rw e_reg e_data
        vecs[0] = '{1'b1, 1'b0, 1'b0, 16'hABCD, 16'h0000, 3'd5, 1'b1, 3'd5, 16'hABCD};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 16'h1111, 16'h0000, 3'd2, 1'b0, 3'd2, 16'h1111};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 16'h5A5A, 16'hFFFF, 3'd7, 1'b1, 3'd7, 16'h5A5A};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b1, 3'd0, 16'h0000};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h1234, 3'd6, 1'b1, 3'd6, 16'hFFFF};

        // reset held while the clock runs, with a stray ack present
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 16'h0, 16'h0, 3'd0);
        dmem_ack = 1'b1;
        dmem_rdata = 16'h5555;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dmem_req", dmem_req, 1'b0);
        chk("rst_dmem_we", dmem_we, 1'b0);
        chk("rst_dmem_addr", dmem_addr, 16'h0);
        chk("rst_dmem_wdata", dmem_wdata, 16'h0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_bus_err", bus_err, 1'b0);
        chk("rst_wb_reg_write", wb_reg_write, 1'b0);
        chk("rst_wb_write_reg", wb_write_reg, 3'd0);
        chk("rst_wb_write_data", wb_write_data, 16'h0);
        chk("rst_state", dbg_state, 1'b0);
        dmem_ack = 1'b0;
        rst_n = 1'b1;

        // single-cycle ALU / non-access vectors
        for (int i = 0; i < 5; i++) begin
            set_in(vecs[i].rw, 0, 0, vecs[i].m2r, vecs[i].alu, 16'h0, vecs[i].wreg);
            dmem_ack   = vecs[i].ack;
            dmem_rdata = vecs[i].rdata;
            #1;
            chk($sformatf("vec%0d_stall", i), stall, 1'b0);
            chk($sformatf("vec%0d_req", i), dmem_req, 1'b0);
            tick();
            dmem_ack = 1'b0;
            chk($sformatf("vec%0d_wb_reg_write", i), wb_reg_write, vecs[i].e_rw);
            chk($sformatf("vec%0d_wb_write_reg", i), wb_write_reg, vecs[i].e_reg);
            chk($sformatf("vec%0d_wb_write_data", i), wb_write_data, vecs[i].e_data);
        end

        // load, ack 3 cycles after req
        set_in(1, 1, 0, 1, 16'h0040, 16'h0, 3'd3);
        do_access(3, 16'h1234);
        chk("ld_done", finished, 1'b1);
        chk("ld_stall_cycles", n_stall, 4);
        chk("ld_latency", n_cyc, 5);
        chk("ld_addr", a_seen, 16'h0040);
        chk("ld_we", w_seen, 1'b0);
        chk("ld_bus_stable", stable_ok, 1'b1);
        chk("ld_wb_bubble", bubble_ok, 1'b1);
        chk("ld_no_err", err_k, -1);
        chk("ld_wb_reg_write", wb_reg_write, 1'b1);
        chk("ld_wb_write_reg", wb_write_reg, 3'd3);
        chk("ld_wb_write_data", wb_write_data, 16'h1234);
        chk("ld_req_dropped", dmem_req, 1'b0);

        // store back-to-back with the load, immediate ack
        set_in(0, 0, 1, 0, 16'h0010, 16'hBEEF, 3'd1);
        do_access(0, 16'h0000);
        set_in(0, 0, 0, 0, 16'h0, 16'h0, 3'd0);
        chk("st_done", finished, 1'b1);
        chk("st_stall_cycles", n_stall, 1);
        chk("st_latency", n_cyc, 2);
        chk("st_addr", a_seen, 16'h0010);
        chk("st_wdata", d_seen, 16'hBEEF);
        chk("st_we", w_seen, 1'b1);
        chk("st_wb_reg_write", wb_reg_write, 1'b0);
        chk("st_wb_write_data", wb_write_data, 16'h0010);
        tick();

        // read+write together behaves as a store
        set_in(1, 1, 1, 1, 16'h0020, 16'hCAFE, 3'd4);
        do_access(1, 16'h9999);
        set_in(0, 0, 0, 0, 16'h0, 16'h0, 3'd0);
        chk("rw_stall_cycles", n_stall, 2);
        chk("rw_we", w_seen, 1'b1);
        chk("rw_wdata", d_seen, 16'hCAFE);
        chk("rw_wb_reg_write", wb_reg_write, 1'b1);
        chk("rw_wb_write_data", wb_write_data, 16'h0020);
        tick();

        // load that never gets an ack
        set_in(1, 1, 0, 1, 16'h0080, 16'h0, 3'd2);
        do_access(-1, 16'h7777);
        set_in(0, 0, 0, 0, 16'h0, 16'h0, 3'd0);
        #1;
        chk("to_done", finished, 1'b1);
        chk("to_err_cycle", err_k, TO);
        chk("to_stall_cycles", n_stall, TO + 1);
        chk("to_bus_stable", stable_ok, 1'b1);
        chk("to_wb_reg_write", wb_reg_write, 1'b0);
        chk("to_wb_write_data", wb_write_data, 16'h0);
        chk("to_req_dropped", dmem_req, 1'b0);
        chk("to_err_pulse_end", bus_err, 1'b0);
        tick();

        // ack on the timeout cycle counts as ack
        set_in(1, 1, 0, 1, 16'h0080, 16'h0, 3'd2);
        do_access(TO, 16'h4321);
        set_in(0, 0, 0, 0, 16'h0, 16'h0, 3'd0);
        chk("tack_no_err", err_k, -1);
        chk("tack_stall_cycles", n_stall, TO + 1);
        chk("tack_wb_reg_write", wb_reg_write, 1'b1);
        chk("tack_wb_write_data", wb_write_data, 16'h4321);
        tick();

        // reset asserted mid-WAIT, then a late ack
        set_in(1, 1, 0, 1, 16'h00C0, 16'h0, 3'd6);
        tick();
        tick();
        chk("mr_req_in_wait", dmem_req, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_req_async", dmem_req, 1'b0);
        chk("mr_stall_async", stall, 1'b0);
        chk("mr_state_async", dbg_state, 1'b0);
        chk("mr_bus_err", bus_err, 1'b0);
        set_in(0, 0, 0, 0, 16'h0, 16'h0, 3'd0);
        tick();
        rst_n = 1'b1;
        dmem_ack = 1'b1;
        dmem_rdata = 16'hAAAA;
        #1;
        chk("mr_late_ack_stall", stall, 1'b0);
        tick();
        dmem_ack = 1'b0;
        chk("mr_late_ack_wb_reg_write", wb_reg_write, 1'b0);
        chk("mr_late_ack_wb_write_data", wb_write_data, 16'h0);
        chk("mr_late_ack_req", dmem_req, 1'b0);
        chk("mr_late_ack_state", dbg_state, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
